// File: rtl/calc_pkg.sv
// Shared types and helpers for the accumulator calculator.
package calc_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_CLR  = 3'b110,
    OP_UNDO = 3'b111
  } opcode_e;

  typedef enum logic [0:0] {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  // Wraps a history pointer back into 0..depth-1. The caller never passes a
  // value of 2*depth or more, so one conditional subtract is enough and no
  // divider is needed for non-power-of-two depths.
  function automatic int unsigned hist_wrap(input int unsigned ptr,
                                            input int unsigned depth);
    return (ptr >= depth) ? ptr - depth : ptr;
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential shift-add multiplier, LSB-first, one multiplier bit per cycle.
//
// Handshake: start_i is sampled only while state_o == MUL_IDLE; the unit is
// busy whenever state_o == MUL_RUN. done_o is a combinational one-cycle
// pulse during the last RUN cycle, and product_o carries the final product
// in that same cycle, so the parent can capture it at the edge where the
// unit drops back to MUL_IDLE. product_o is meaningless when done_o is low.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int ACC_W  = 8,
  parameter int OPND_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [ACC_W-1:0]     mcand_i,
  input  logic [OPND_W-1:0]    mplier_i,
  output logic                 done_o,
  output logic [2*ACC_W-1:0]   product_o,
  output logic [0:0]           state_o
);

  localparam int MW    = 2 * ACC_W;
  localparam int CNT_W = $clog2(OPND_W + 1);

  mul_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MW-1:0]       mcand_q, mcand_d;
  logic [OPND_W-1:0]   mplier_q, mplier_d;
  logic [MW-1:0]       prod_q, prod_d;
  logic [MW-1:0]       step_sum;

  assign step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign state_o  = state_q;

  // State and datapath registers; reset abandons any product in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // Next-state: load on start, then add the shifted multiplicand per set bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    done_o    = 1'b0;
    product_o = step_sum;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d  = MUL_RUN;
          cnt_d    = '0;
          mcand_d  = MW'(mcand_i);
          mplier_d = mplier_i;
          prod_d   = '0;
        end
      end
      MUL_RUN: begin
        prod_d   = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OPND_W - 1)) begin
          done_o  = 1'b1;
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

endmodule

// File: rtl/calc_accumulator.sv
// Accumulator calculator: one command per rising edge of en, multi-cycle
// MUL, flags, and a circular undo history.
module calc_accumulator
  import calc_pkg::*;
#(
  parameter int ACC_W      = 8,
  parameter int OPND_W     = 3,
  parameter int HIST_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [OPND_W-1:0] operand,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              zero,
  output logic              carry,
  output logic              err,
  output logic              hist_empty
);

  localparam int PTR_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int HCNT_W = $clog2(HIST_DEPTH + 1);

  logic                en_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                err_q, err_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [ACC_W-1:0]    hist_q [HIST_DEPTH];

  logic                push, pop, mul_start, mul_done;
  logic [0:0]          mul_state;
  logic [2*ACC_W-1:0]  mul_product;
  logic                cmd_edge, accept;
  opcode_e             op;
  logic [ACC_W-1:0]    opnd_x;
  logic [ACC_W:0]      sum_w, diff_w, shl_w, shr_w;
  logic [PTR_W-1:0]    next_ptr, prev_ptr;

  assign op       = opcode_e'(opcode);
  assign busy     = (mul_state == MUL_RUN);
  assign cmd_edge = en & ~en_q;
  assign accept   = cmd_edge & ~busy;
  assign opnd_x   = ACC_W'(operand);

  // Extra top bit carries out/borrow for add/sub and holds the last bit
  // shifted out for the shifts (zero for a shift of 0 or beyond ACC_W).
  assign sum_w  = {1'b0, acc_q} + {1'b0, opnd_x};
  assign diff_w = {1'b0, acc_q} - {1'b0, opnd_x};
  assign shl_w  = {1'b0, acc_q} << operand;
  assign shr_w  = {acc_q, 1'b0} >> operand;

  // head_q is the next slot to write; the newest entry sits one behind it.
  assign next_ptr = PTR_W'(hist_wrap(32'(head_q) + 32'd1, HIST_DEPTH));
  assign prev_ptr = PTR_W'(hist_wrap(32'(head_q) + HIST_DEPTH - 1, HIST_DEPTH));

  assign acc        = acc_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign err        = err_q;
  assign hist_empty = (hcnt_q == '0);

  calc_mul_seq #(
    .ACC_W  (ACC_W),
    .OPND_W (OPND_W)
  ) u_mul (
    .clock     (clock),
    .reset     (reset),
    .start_i   (mul_start),
    .mcand_i   (acc_q),
    .mplier_i  (operand),
    .done_o    (mul_done),
    .product_o (mul_product),
    .state_o   (mul_state)
  );

  // Architectural state; en_q tracks en every cycle, busy or not.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q    <= 1'b0;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      head_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      en_q    <= en;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      head_q  <= head_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // History storage needs no reset: the count decides which slots are valid.
  always_ff @(posedge clock) begin
    if (push) hist_q[head_q] <= acc_q;
  end

  // Command decode, MUL completion and history pointer bookkeeping.
  always_comb begin
    acc_d     = acc_q;
    carry_d   = carry_q;
    err_d     = err_q;
    head_d    = head_q;
    hcnt_d    = hcnt_q;
    push      = 1'b0;
    pop       = 1'b0;
    mul_start = 1'b0;

    if (cmd_edge && busy) err_d = 1'b1;

    if (mul_done) begin
      acc_d   = mul_product[ACC_W-1:0];
      carry_d = |mul_product[2*ACC_W-1:ACC_W];
    end

    if (accept) begin
      push = (op != OP_UNDO);
      case (op)
        OP_ADD: begin acc_d = sum_w[ACC_W-1:0];  carry_d = sum_w[ACC_W];  end
        OP_SUB: begin acc_d = diff_w[ACC_W-1:0]; carry_d = diff_w[ACC_W]; end
        OP_XOR: begin acc_d = acc_q ^ opnd_x;    carry_d = 1'b0;          end
        OP_SHL: begin acc_d = shl_w[ACC_W-1:0];  carry_d = shl_w[ACC_W];  end
        OP_SHR: begin acc_d = shr_w[ACC_W:1];    carry_d = shr_w[0];      end
        OP_MUL: mul_start = 1'b1;
        OP_CLR: begin acc_d = '0;                carry_d = 1'b0;          end
        OP_UNDO: begin
          if (hcnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            pop   = 1'b1;
            acc_d = hist_q[prev_ptr];
          end
        end
        default: ;
      endcase
    end

    if (push) begin
      head_d = next_ptr;
      if (hcnt_q != HCNT_W'(HIST_DEPTH)) hcnt_d = hcnt_q + HCNT_W'(1);
    end else if (pop) begin
      head_d = prev_ptr;
      hcnt_d = hcnt_q - HCNT_W'(1);
    end

    zero_d = (acc_d == '0);
  end

endmodule

// File: tb/tb_calc_accumulator.sv
// Bench for calc_accumulator: directed scenarios plus random commands,
// checked every cycle against a behavioural model.
module tb_calc_accumulator;

  localparam int ACC_W      = 8;
  localparam int OPND_W     = 3;
  localparam int HIST_DEPTH = 4;
  localparam longint MASK   = (64'd1 << ACC_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [2:0]        opcode = 3'd0;
  logic [OPND_W-1:0] operand = '0;
  logic [ACC_W-1:0]  acc;
  logic              busy, zero, carry, err, hist_empty;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Behavioural model state
  longint m_acc = 0;
  bit     m_zero = 1'b1, m_carry = 1'b0, m_err = 1'b0, m_en_q = 1'b0;
  int     m_left = 0;
  longint m_pend_acc = 0;
  bit     m_pend_carry = 1'b0;
  longint hist[$];

  calc_accumulator #(
    .ACC_W      (ACC_W),
    .OPND_W     (OPND_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .opcode     (opcode),
    .operand    (operand),
    .acc        (acc),
    .busy       (busy),
    .zero       (zero),
    .carry      (carry),
    .err        (err),
    .hist_empty (hist_empty)
  );

  // Clock
  always #5 clock = ~clock;

  // Executes one accepted command on the model using plain integer math.
  function automatic void model_exec(input int op, input int k);
    longint p;
    if (op != 7) begin
      hist.push_back(m_acc);
      if (hist.size() > HIST_DEPTH) void'(hist.pop_front());
    end
    case (op)
      0: begin p = m_acc + k; m_carry = (p > MASK); m_acc = p & MASK; end
      1: begin m_carry = (k > m_acc); m_acc = (m_acc - k) & MASK; end
      2: begin m_acc = m_acc ^ k; m_carry = 1'b0; end
      3: begin
        m_carry = (k >= 1 && k <= ACC_W) ? (((m_acc >> (ACC_W - k)) & 1) != 0) : 1'b0;
        m_acc   = (k >= ACC_W) ? 0 : ((m_acc << k) & MASK);
      end
      4: begin
        m_carry = (k >= 1 && k <= ACC_W) ? (((m_acc >> (k - 1)) & 1) != 0) : 1'b0;
        m_acc   = (k >= ACC_W) ? 0 : (m_acc >> k);
      end
      5: begin
        p = m_acc * k;
        m_pend_acc   = p & MASK;
        m_pend_carry = (p > MASK);
        m_left       = OPND_W;
      end
      6: begin m_acc = 0; m_carry = 1'b0; end
      default: begin
        if (hist.size() == 0) m_err = 1'b1;
        else m_acc = hist.pop_back();
      end
    endcase
  endfunction

  // Model advances at each rising clock edge from the same inputs the DUT sees.
  always @(posedge clock) begin
    bit rise;
    if (reset) begin
      m_acc = 0; m_zero = 1'b1; m_carry = 1'b0; m_err = 1'b0;
      m_left = 0; m_en_q = 1'b0;
      hist.delete();
    end else begin
      rise   = en && !m_en_q;
      m_en_q = en;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_acc   = m_pend_acc;
          m_carry = m_pend_carry;
        end
        if (rise) m_err = 1'b1;
      end else if (rise) begin
        model_exec(int'(opcode), int'(operand));
      end
      m_zero = (m_acc == 0);
    end
  end

  // Scoreboard compare on the falling edge, every cycle once reset has been seen.
  always @(negedge clock) begin
    if (chk_on) begin
      total++;
      if ({acc, busy, zero, carry, err, hist_empty} !==
          {8'(m_acc), (m_left > 0), m_zero, m_carry, m_err, (hist.size() == 0)}) begin
        bad++;
        $display("FAIL model_cmp t=%0t dut acc=%0h busy=%0b zero=%0b carry=%0b err=%0b he=%0b model acc=%0h busy=%0b zero=%0b carry=%0b err=%0b he=%0b",
                 $time, acc, busy, zero, carry, err, hist_empty,
                 8'(m_acc), (m_left > 0), m_zero, m_carry, m_err, (hist.size() == 0));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one command: en high for one edge, then low for one edge.
  task automatic cmd(input int op, input int k);
    en = 1'b1; opcode = 3'(op); operand = OPND_W'(k);
    @(negedge clock);
    en = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clock);
    chk_on = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_acc", 32'(acc), 32'h0);
    chk("rst_flags", {28'd0, busy, zero, carry, err}, 32'b0100);
    chk("rst_hist_empty", 32'(hist_empty), 32'd1);

    // ADD 5, ADD 7
    cmd(0, 5);
    cmd(0, 7);
    chk("add_acc", 32'(acc), 32'd12);
    chk("add_flags", {29'd0, carry, zero, hist_empty}, 32'b000);

    // MUL 5 from 12, with an en edge while busy
    en = 1'b1; opcode = 3'd5; operand = 3'd5;
    @(negedge clock);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      en = (n == 2);
      @(negedge clock);
    end
    en = 1'b0;
    chk("mul_busy_cycles", 32'(n), 32'd3);
    chk("mul_acc", 32'(acc), 32'd60);
    chk("mul_carry_err", {30'd0, carry, err}, 32'b01);

    // SUB / XOR
    do_reset();
    cmd(1, 1);
    chk("sub_acc", 32'(acc), 32'hFF);
    chk("sub_carry", 32'(carry), 32'd1);
    cmd(2, 7);
    chk("xor_acc", 32'(acc), 32'hF8);
    chk("xor_carry", 32'(carry), 32'd0);

    // Shifts
    cmd(6, 0); cmd(0, 1); cmd(3, 7); cmd(0, 1);
    chk("build_81", 32'(acc), 32'h81);
    cmd(3, 1);
    chk("shl1_acc", 32'(acc), 32'h02);
    chk("shl1_carry", 32'(carry), 32'd1);
    cmd(3, 0);
    chk("shl0_acc", 32'(acc), 32'h02);
    chk("shl0_carry", 32'(carry), 32'd0);
    cmd(6, 0); cmd(0, 1); cmd(3, 7);
    cmd(4, 7);
    chk("shr7_acc", 32'(acc), 32'h01);
    chk("shr7_carry", 32'(carry), 32'd0);

    // History wrap and UNDO
    do_reset();
    repeat (5) cmd(0, 1);
    chk("hist_acc5", 32'(acc), 32'd5);
    for (int i = 4; i >= 1; i--) begin
      cmd(7, 0);
      chk("undo_acc", 32'(acc), 32'(i));
    end
    cmd(7, 0);
    chk("undo_empty_acc", 32'(acc), 32'd1);
    chk("undo_empty_flags", {30'd0, err, hist_empty}, 32'b11);

    // Held en issues one command; reset aborts MUL
    do_reset();
    en = 1'b1; opcode = 3'd0; operand = 3'd3;
    repeat (10) @(negedge clock);
    en = 1'b0;
    @(negedge clock);
    chk("hold_acc", 32'(acc), 32'd3);
    en = 1'b1; opcode = 3'd5; operand = 3'd7;
    @(negedge clock);
    en = 1'b0;
    chk("mul7_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_acc", 32'(acc), 32'd0);
    chk("abort_flags", {29'd0, busy, err, hist_empty}, 32'b001);

    // Random commands
    repeat (800) begin
      en      = 1'($urandom_range(0, 1));
      opcode  = 3'($urandom_range(0, 7));
      operand = OPND_W'($urandom_range(0, (1 << OPND_W) - 1));
      reset   = ($urandom_range(0, 149) == 0);
      @(negedge clock);
    end
    reset = 1'b0; en = 1'b0;
    repeat (OPND_W + 2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
